// File: rtl/inst_enc.sv
// inst_enc: two-stage pipelined encoder for 32-bit I/S/B/U/J/R instruction words.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready held low during reset)
//   imm_sel                  1 I, 2 S, 3 B, 4 U, 5 J; any other value selects R
//   imm                      signed immediate / byte offset
//   opcode, rd, rs1, rs2,
//   funct3, funct7           instruction fields
//   out_valid / out_ready    result handshake
//   inst_out                 packed instruction word
//   range_err                immediate not representable in the chosen format
//                            (the truncated packing is still delivered)
//   enc_count                saturating count of completed output handshakes
module inst_enc #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             imm_sel,
  input  logic [31:0]            imm,
  input  logic [6:0]             opcode,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [2:0]             funct3,
  input  logic [6:0]             funct7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            inst_out,
  output logic                   range_err,
  output logic [COUNT_WIDTH-1:0] enc_count
);

  logic               s1_valid;
  logic [31:0]        s1_word;
  logic               s1_err;
  logic [31:0]        enc_word;
  logic               enc_err;
  logic               advance;
  logic               s1_load;
  logic signed [31:0] imm_s;

  assign imm_s = imm;

  // The output register moves whenever it is empty or being consumed; S1
  // moves in lockstep, but an empty S1 may always take a new request so the
  // pipeline fills two deep while the consumer stalls.
  assign advance  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || advance;
  assign in_ready = !rst && s1_load;

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (imm_sel)
      3'd1: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      3'd2: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
      end
      3'd4: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_err  = (imm[11:0] != 12'd0);
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
      end
      default: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_word   <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      inst_out  <= '0;
      range_err <= 1'b0;
      enc_count <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_word <= enc_word;
        s1_err  <= enc_err;
      end
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          inst_out  <= s1_word;
          range_err <= s1_err;
        end
      end
      if (out_valid && out_ready && (enc_count != '1)) begin
        enc_count <= enc_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_enc.sv
module tb_inst_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_out;
  logic        range_err;
  logic [15:0] enc_count;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          exp_count = 0;

  always #5 clk = ~clk;

  inst_enc #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .inst_out(inst_out), .range_err(range_err),
    .enc_count(enc_count)
  );

  // Reference encoder: bit placement by shifts/masks, range rules by integer compare.
  function automatic logic [32:0] ref_enc(input logic [2:0] sel, input logic [31:0] v,
                                          input logic [6:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] f3, input logic [6:0] f7);
    longint    sv;
    bit [31:0] w;
    bit        e;
    sv = longint'($signed(v));
    w = 32'(op) | (32'(f3) << 12);
    e = 1'b0;
    case (sel)
      3'd1: begin
        w = 32'(op) | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15) | ((v & 32'hFFF) << 20);
        e = (sv < -2048) || (sv > 2047);
      end
      3'd2: begin
        w = w | ((v & 32'h1F) << 7) | (32'(s1) << 15) | (32'(s2) << 20) | (((v >> 5) & 32'h7F) << 25);
        e = (sv < -2048) || (sv > 2047);
      end
      3'd3: begin
        w = w | (((v >> 11) & 32'h1) << 7) | (((v >> 1) & 32'hF) << 8) | (32'(s1) << 15)
              | (32'(s2) << 20) | (((v >> 5) & 32'h3F) << 25) | (((v >> 12) & 32'h1) << 31);
        e = (sv < -4096) || (sv > 4094) || ((sv % 2) != 0);
      end
      3'd4: begin
        w = (v & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
        e = (v % 4096) != 0;
      end
      3'd5: begin
        w = 32'(op) | (32'(d) << 7) | (((v >> 12) & 32'hFF) << 12) | (((v >> 11) & 32'h1) << 20)
              | (((v >> 1) & 32'h3FF) << 21) | (((v >> 20) & 32'h1) << 31);
        e = (sv < -1048576) || (sv > 1048574) || ((sv % 2) != 0);
      end
      default: begin
        w = w | (32'(d) << 7) | (32'(s1) << 15) | (32'(s2) << 20) | (32'(f7) << 25);
      end
    endcase
    return {e, w};
  endfunction

  // Handshake monitor: records accepted requests (as model results) and delivered outputs.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      exp_count = 0;
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back(ref_enc(imm_sel, imm, opcode, rd, rs1, rs2, funct3, funct7));
      if (out_valid && out_ready) begin
        got_q.push_back({range_err, inst_out});
        if (exp_count < 65535) exp_count++;
      end
    end
  end

  task automatic set_fields(input logic [2:0] sel, input logic [31:0] v, input logic [6:0] op,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [2:0] f3, input logic [6:0] f7);
    imm_sel = sel; imm = v; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
  endtask

  function automatic logic [31:0] pick_imm();
    logic [31:0] b[19];
    b = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, 32'd4095, 32'd4096, -32'd4096,
          -32'd4097, -32'd4098, 32'd1048574, 32'd1048575, 32'd1048576, -32'd1048576,
          -32'd1048577, -32'd1048578, 32'd0, 32'd1, -32'd1};
    case ($urandom_range(0, 3))
      0: return b[$urandom_range(0, 18)];
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return $urandom() & 32'hFFFFF000;
      default: return $urandom();
    endcase
  endfunction

  task automatic pulse_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (inst_out !== 32'd0) begin failures++; $display("FAIL reset_inst_out: got %h expected 0", inst_out); end
    checks++; if (range_err !== 1'b0) begin failures++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
    checks++; if (enc_count !== 16'd0) begin failures++; $display("FAIL reset_enc_count: got %0d expected 0", enc_count); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] v;
    logic [6:0]  op;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic [31:0] inst;
    logic        err;
    logic        check_low_only;
  } vec_t;

  task automatic test_directed();
    vec_t t[6];
    t[0] = '{3'd1, -32'd100,      7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hF9C00093, 1'b0, 1'b0};
    t[1] = '{3'd3, -32'd4,        7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE000EE3, 1'b0, 1'b0};
    t[2] = '{3'd3, 32'd3,         7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000163, 1'b1, 1'b0};
    t[3] = '{3'd1, 32'd2048,      7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h80000093, 1'b1, 1'b1};
    t[4] = '{3'd4, 32'h12345000,  7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 1'b0, 1'b0};
    t[5] = '{3'd4, 32'h12345001,  7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h123452B7, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_fields(t[i].sel, t[i].v, t[i].op, t[i].d, t[i].s1, t[i].s2, t[i].f3, 7'd0);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk); #2;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      set_fields(3'd0, $urandom(), 7'h7F, 5'h1F, 5'h1F, 5'h1F, 3'd7, 7'h7F);
      @(negedge clk); #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_latency1: got out_valid %b expected 0", i, out_valid); end
      @(posedge clk);
      @(negedge clk); #2;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_latency2: got out_valid %b expected 1", i, out_valid); end
      if (t[i].check_low_only) begin
        checks++; if (inst_out[31:20] !== t[i].inst[31:20]) begin failures++; $display("FAIL dir%0d_imm_field: got %h expected %h", i, inst_out[31:20], t[i].inst[31:20]); end
      end else begin
        checks++; if (inst_out !== t[i].inst) begin failures++; $display("FAIL dir%0d_inst: got %h expected %h", i, inst_out, t[i].inst); end
      end
      checks++; if (range_err !== t[i].err) begin failures++; $display("FAIL dir%0d_err: got %b expected %b", i, range_err, t[i].err); end
    end
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [32:0] req[3];
    logic [31:0] held;
    int          idx;
    int          base;
    pulse_reset(2);
    for (int i = 0; i < 3; i++) req[i] = {1'b0, $urandom()};
    idx = 0;
    held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      in_valid = (idx < 3);
      if (idx < 3) set_fields(3'd1, 32'($urandom_range(0, 4095)) - 32'd2048, req[idx][6:0],
                              req[idx][11:7], req[idx][16:12], req[idx][21:17], req[idx][24:22], 7'd0);
      @(negedge clk); #2;
      if (in_valid && in_ready) idx++;
      if (c == 3) held = inst_out;
      if (c > 3) begin
        checks++; if (inst_out !== held) begin failures++; $display("FAIL bp_hold: got %h expected %h", inst_out, held); end
      end
    end
    checks++; if (idx !== 2) begin failures++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    base = 0;
    for (int c = 0; c < 20 && got_q.size() < 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = (idx < 3);
      @(negedge clk); #2;
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL bp_delivered: got %0d expected 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL bp_order%0d: got %h expected %h", base, g, e); end
      base++;
    end
    checks++; if (enc_count !== 16'd3) begin failures++; $display("FAIL bp_enc_count: got %0d expected 3", enc_count); end
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [32:0] prev_out;
    int          n;
    prev_stall = 1'b0;
    prev_out = '0;
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      set_fields(3'($urandom_range(0, 7)), pick_imm(), 7'($urandom()), 5'($urandom()),
                 5'($urandom()), 5'($urandom()), 3'($urandom()), 7'($urandom()));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk); #2;
      if (prev_stall) begin
        checks++; if ({range_err, inst_out} !== prev_out || out_valid !== 1'b1) begin failures++; $display("FAIL rnd_hold: got %h expected %h", {range_err, inst_out}, prev_out); end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {range_err, inst_out};
      while (got_q.size() > 0) begin
        logic [32:0] g, e;
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_extra: got %h expected none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin failures++; $display("FAIL rnd_item%0d: got %h expected %h", n, g, e); end
        end
        n++;
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); #2;
      while (got_q.size() > 0) begin
        logic [32:0] g, e;
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_drain_extra: got %h expected none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin failures++; $display("FAIL rnd_drain%0d: got %h expected %h", n, g, e); end
        end
        n++;
      end
    end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rnd_dropped: got %0d undelivered expected 0", exp_q.size()); end
    checks++; if (32'(enc_count) !== 32'(exp_count)) begin failures++; $display("FAIL rnd_enc_count: got %0d expected %0d", enc_count, exp_count); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      set_fields(3'd0, $urandom(), 7'($urandom()), 5'($urandom()), 5'($urandom()),
                 5'($urandom()), 3'($urandom()), 7'($urandom()));
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (enc_count !== 16'd0) begin failures++; $display("FAIL mid_enc_count: got %0d expected 0", enc_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    repeat (8) @(posedge clk);
    @(negedge clk); #2;
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL mid_stale: got %0d outputs expected 0", got_q.size()); end
    checks++; if (enc_count !== 16'd0) begin failures++; $display("FAIL mid_count_after: got %0d expected 0", enc_count); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(3'd0, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
